// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit ALU logic unit and its checker:
// select codes, checker FSM states and the reference logic function.
package alu_pkg;

    localparam int LU_W = 64;

    localparam logic [2:0] LU_AND   = 3'd0;
    localparam logic [2:0] LU_OR    = 3'd1;
    localparam logic [2:0] LU_XOR   = 3'd2;
    localparam logic [2:0] LU_NAND  = 3'd3;
    localparam logic [2:0] LU_NOR   = 3'd4;
    localparam logic [2:0] LU_XNOR  = 3'd5;
    localparam logic [2:0] LU_NOT0  = 3'd6;
    localparam logic [2:0] LU_PASS0 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chk_state_t;

    function automatic logic [LU_W-1:0] lu_expected(
        input logic [LU_W-1:0] in_0,
        input logic [LU_W-1:0] in_1,
        input logic [2:0]      sel
    );
        logic [LU_W-1:0] r;
        r = in_0;
        case (sel)
            LU_AND:   r = in_0 & in_1;
            LU_OR:    r = in_0 | in_1;
            LU_XOR:   r = in_0 ^ in_1;
            LU_NAND:  r = ~(in_0 & in_1);
            LU_NOR:   r = ~(in_0 | in_1);
            LU_XNOR:  r = ~(in_0 ^ in_1);
            LU_NOT0:  r = ~in_0;
            LU_PASS0: r = in_0;
            default:  r = in_0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_ref.sv
// Combinational reference model of the logic unit (WIDTH <= 64).
// Ports: in_0, in_1 operands; sel select code; expected result.
module logic_unit_ref
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] expected
);

    logic [LU_W-1:0] full;

    // Zero-extension is harmless: every operation is bitwise,
    // so the upper bits are simply discarded afterwards.
    always_comb begin
        full = lu_expected(LU_W'(in_0), LU_W'(in_1), sel);
    end

    assign expected = full[WIDTH-1:0];

endmodule

// File: rtl/logic_unit_checker.sv
// Response checker for the ALU logic unit: valid/ready intake, 2-stage
// recompute/compare pipeline, saturating pass/fail counters and
// first-failure capture.
// Ports: clk, rst_n (sync, active low), start; t_valid/t_ready handshake
// with t_in_0, t_in_1, t_sel, t_out; mismatch pulse, pass_cnt, fail_cnt,
// first_fail_idx, first_fail_exp, busy, done.
module logic_unit_checker
    import alu_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int CNT_W        = 16,
    parameter int NUM_VECTORS  = 10,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             t_valid,
    output logic             t_ready,
    input  logic [WIDTH-1:0] t_in_0,
    input  logic [WIDTH-1:0] t_in_1,
    input  logic [2:0]       t_sel,
    input  logic [WIDTH-1:0] t_out,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic             busy,
    output logic             done
);

    chk_state_t state;
    chk_state_t state_nxt;

    logic [CNT_W-1:0] acc_cnt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_in_0;
    logic [WIDTH-1:0] s1_in_1;
    logic [2:0]       s1_sel;
    logic [WIDTH-1:0] s1_out;
    logic [CNT_W-1:0] s1_idx;

    logic [WIDTH-1:0] exp_val;
    logic             accept;
    logic             last_accept;
    logic             cmp_fail;
    logic             clear;

    logic_unit_ref #(
        .WIDTH(WIDTH)
    ) u_ref (
        .in_0     (s1_in_0),
        .in_1     (s1_in_1),
        .sel      (s1_sel),
        .expected (exp_val)
    );

    assign t_ready     = (state == ST_RUN);
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign accept      = t_valid && t_ready;
    assign last_accept = accept && (acc_cnt == CNT_W'(NUM_VECTORS - 1));
    assign cmp_fail    = s1_valid && (exp_val != s1_out);
    assign clear       = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_accept || ((STOP_ON_FAIL != 0) && cmp_fail))
                    state_nxt = ST_DRAIN;
            end
            // Stage 1 holds at most one entry and nothing enters while
            // draining, so it is always compared during this cycle.
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE: begin
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            acc_cnt        <= '0;
            s1_valid       <= 1'b0;
            s1_in_0        <= '0;
            s1_in_1        <= '0;
            s1_sel         <= '0;
            s1_out         <= '0;
            s1_idx         <= '0;
            mismatch       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            mismatch <= cmp_fail;

            if (accept) begin
                s1_in_0 <= t_in_0;
                s1_in_1 <= t_in_1;
                s1_sel  <= t_sel;
                s1_out  <= t_out;
                s1_idx  <= acc_cnt;
            end

            if (clear) begin
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
            end

            if (clear) begin
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                first_fail_idx <= '0;
                first_fail_exp <= '0;
            end else if (s1_valid) begin
                if (cmp_fail) begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    if (fail_cnt == '0) begin
                        first_fail_idx <= s1_idx;
                        first_fail_exp <= exp_val;
                    end
                end else if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_checker.sv
// Self-checking bench for logic_unit_checker: three instances (default,
// stop-on-fail, narrow counters) share stimulus; scoreboard on mismatch.
module tb_logic_unit_checker;

    localparam logic [63:0] OP_A = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] OP_B = 64'h0F0F0F0F0F0F0F0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic        t_valid;
    logic [63:0] t_in_0, t_in_1, t_out;
    logic [2:0]  t_sel;

    logic        ready_a, mis_a, busy_a, done_a;
    logic [15:0] pass_a, fail_a, ffi_a;
    logic [63:0] ffe_a;
    logic        ready_b, mis_b, busy_b, done_b;
    logic [15:0] pass_b, fail_b, ffi_b;
    logic [63:0] ffe_b;
    logic        ready_c, mis_c, busy_c, done_c;
    logic [2:0]  pass_c, fail_c, ffi_c;
    logic [63:0] ffe_c;

    int vectors = 0;
    int miscompares = 0;
    int sel_dut = 0;

    logic ready_m, mis_m, done_m;
    bit   exp_q[$];
    bit   mon_e;
    bit   d1 = 1'b0, d2 = 1'b0;

    always #5 clk = ~clk;

    logic_unit_checker dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .t_valid(t_valid),
        .t_ready(ready_a), .t_in_0(t_in_0), .t_in_1(t_in_1),
        .t_sel(t_sel), .t_out(t_out), .mismatch(mis_a),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail_idx(ffi_a),
        .first_fail_exp(ffe_a), .busy(busy_a), .done(done_a)
    );

    logic_unit_checker #(.STOP_ON_FAIL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .t_valid(t_valid),
        .t_ready(ready_b), .t_in_0(t_in_0), .t_in_1(t_in_1),
        .t_sel(t_sel), .t_out(t_out), .mismatch(mis_b),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail_idx(ffi_b),
        .first_fail_exp(ffe_b), .busy(busy_b), .done(done_b)
    );

    logic_unit_checker #(.CNT_W(3), .NUM_VECTORS(7)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .t_valid(t_valid),
        .t_ready(ready_c), .t_in_0(t_in_0), .t_in_1(t_in_1),
        .t_sel(t_sel), .t_out(t_out), .mismatch(mis_c),
        .pass_cnt(pass_c), .fail_cnt(fail_c), .first_fail_idx(ffi_c),
        .first_fail_exp(ffe_c), .busy(busy_c), .done(done_c)
    );

    always_comb begin
        ready_m = ready_a;
        mis_m   = mis_a;
        done_m  = done_a;
        if (sel_dut == 1) begin
            ready_m = ready_b;
            mis_m   = mis_b;
            done_m  = done_b;
        end else if (sel_dut == 2) begin
            ready_m = ready_c;
            mis_m   = mis_c;
            done_m  = done_c;
        end
    end

    function automatic logic [63:0] ref_lu(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [2:0] s);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Scoreboard: push expected mismatch at handshake, compare 2 cycles on.
    always @(negedge clk) begin
        if (d2) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: result with no pending entry");
            end else begin
                mon_e = exp_q.pop_front();
                if (mis_m !== mon_e) begin
                    miscompares++;
                    $display("FAIL mismatch_pulse: got %b want %b", mis_m, mon_e);
                end
            end
        end else if (rst_n === 1'b1 && mis_m !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_mismatch: got %b want 0", mis_m);
        end
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            d1 = 1'b0;
            d2 = 1'b0;
        end else begin
            d2 = d1;
            d1 = t_valid && ready_m;
            if (t_valid && ready_m)
                exp_q.push_back(ref_lu(t_in_0, t_in_1, t_sel) != t_out);
        end
    end

    task automatic drive_vec(input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] s, input bit bad);
        t_in_0  = a;
        t_in_1  = b;
        t_sel   = s;
        t_out   = ref_lu(a, b, s) ^ (bad ? 64'd1 : 64'd0);
        t_valid = 1'b1;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] s, input bit bad);
        bit ok;
        ok = 1'b0;
        drive_vec(a, b, s, bad);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (ready_m === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: got ready=0 want ready=1");
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (done_m === 1'b1);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL done_timeout: got done=0 want done=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        case (which)
            1:       start_b = 1'b1;
            2:       start_c = 1'b1;
            default: start_a = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        vectors++;
        if ({ready_a, busy_a, done_a, mis_a} !== 4'b0) begin
            miscompares++;
            $display("FAIL %s_flags: got rdy/busy/done/mis=%b%b%b%b want 0000",
                     tag, ready_a, busy_a, done_a, mis_a);
        end
        vectors++;
        if (pass_a !== 16'd0 || fail_a !== 16'd0) begin
            miscompares++;
            $display("FAIL %s_counts: got pass=%0d fail=%0d want 0/0",
                     tag, pass_a, fail_a);
        end
        vectors++;
        if (ffi_a !== 16'd0 || ffe_a !== 64'd0) begin
            miscompares++;
            $display("FAIL %s_first: got idx=%0d exp=%h want 0/0",
                     tag, ffi_a, ffe_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_a_zero("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        sel_dut = 0;
        pulse_start(0);
        @(negedge clk);
        vectors++;
        if (ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_start: got %b want 1", ready_a);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send(OP_A, OP_B, 3'(i % 8), 1'b0);
        t_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL done_early: got %b want 0", done_a);
        end
        @(negedge clk);
        vectors++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL done_timing: got done=%b busy=%b want 1/0",
                     done_a, busy_a);
        end
        vectors++;
        if (pass_a !== 16'd10 || fail_a !== 16'd0) begin
            miscompares++;
            $display("FAIL b2b_counts: got pass=%0d fail=%0d want 10/0",
                     pass_a, fail_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_fail();
        sel_dut = 0;
        pulse_start(0);
        for (int i = 0; i < 10; i++)
            send(OP_A, OP_B, (i == 3) ? 3'd2 : 3'(i % 8), i == 3);
        t_valid = 1'b0;
        wait_done();
        vectors++;
        if (pass_a !== 16'd9 || fail_a !== 16'd1) begin
            miscompares++;
            $display("FAIL ff_counts: got pass=%0d fail=%0d want 9/1",
                     pass_a, fail_a);
        end
        vectors++;
        if (ffi_a !== 16'd3 || ffe_a !== (OP_A ^ OP_B)) begin
            miscompares++;
            $display("FAIL ff_capture: got idx=%0d exp=%h want 3/%h",
                     ffi_a, ffe_a, OP_A ^ OP_B);
        end
    endtask

    task automatic test_gaps();
        int gap;
        sel_dut = 0;
        pulse_start(0);
        for (int i = 0; i < 10; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom},
                 3'($urandom_range(0, 7)), 1'b0);
            t_valid = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        t_valid = 1'b0;
        wait_done();
        drive_vec(OP_A, OP_B, 3'd1, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        t_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (pass_a !== 16'd10 || fail_a !== 16'd0 || done_a !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_counts: got pass=%0d fail=%0d done=%b want 10/0/1",
                     pass_a, fail_a, done_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        sel_dut = 0;
        pulse_start(0);
        for (int i = 0; i < 5; i++) send(OP_A, OP_B, 3'(i), i == 4);
        t_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_a_zero("midreset");
        @(posedge clk);
        #1;
        pulse_start(0);
        for (int i = 0; i < 10; i++) send(OP_B, OP_A, 3'(i % 8), 1'b0);
        t_valid = 1'b0;
        wait_done();
        vectors++;
        if (pass_a !== 16'd10 || fail_a !== 16'd0) begin
            miscompares++;
            $display("FAIL rerun_counts: got pass=%0d fail=%0d want 10/0",
                     pass_a, fail_a);
        end
    endtask

    task automatic test_stop_on_fail();
        sel_dut = 1;
        pulse_start(1);
        for (int i = 0; i < 4; i++)
            send(OP_A, OP_B, 3'(i), i == 2);
        drive_vec(OP_A, OP_B, 3'd4, 1'b0);
        @(negedge clk);
        vectors++;
        if (ready_b !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_ready: got %b want 0", ready_b);
        end
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        wait_done();
        vectors++;
        if (pass_b + fail_b !== 16'd4 || fail_b !== 16'd1) begin
            miscompares++;
            $display("FAIL stop_counts: got pass=%0d fail=%0d want 3/1",
                     pass_b, fail_b);
        end
        vectors++;
        if (ffi_b !== 16'd2 || ffe_b !== (OP_A ^ OP_B)) begin
            miscompares++;
            $display("FAIL stop_capture: got idx=%0d exp=%h want 2/%h",
                     ffi_b, ffe_b, OP_A ^ OP_B);
        end
    endtask

    task automatic test_saturation();
        sel_dut = 2;
        pulse_start(2);
        for (int i = 0; i < 7; i++) send(OP_A, OP_B, 3'(i), 1'b1);
        t_valid = 1'b0;
        wait_done();
        vectors++;
        if (fail_c !== 3'd7 || pass_c !== 3'd0) begin
            miscompares++;
            $display("FAIL sat_counts: got pass=%0d fail=%0d want 0/7",
                     pass_c, fail_c);
        end
        vectors++;
        if (ffi_c !== 3'd0 || ffe_c !== (OP_A & OP_B)) begin
            miscompares++;
            $display("FAIL sat_capture: got idx=%0d exp=%h want 0/%h",
                     ffi_c, ffe_c, OP_A & OP_B);
        end
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        t_valid = 1'b0;
        t_in_0  = '0;
        t_in_1  = '0;
        t_sel   = '0;
        t_out   = '0;
        test_reset();
        test_back_to_back();
        test_first_fail();
        test_gaps();
        test_reset_mid();
        test_stop_on_fail();
        test_saturation();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
